// File: rtl/fifo_word_packer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_word_packer_if : byte-fifo read side plus packed-word output stream
// rev 1.0
// ---------------------------------------------------------------------------
interface fifo_word_packer_if #(
   parameter int NBYTES = 4
);
   // byte fifo read port
   logic                  fifo_empty;
   logic [7:0]            fifo_rdata;
   logic                  fifo_ren;

   // packed word stream
   logic                  out_valid;
   logic                  out_ready;
   logic [8*NBYTES-1:0]   out_data;
   logic [NBYTES-1:0]     out_keep;
   logic                  out_last;

   modport master (
      input  fifo_empty,
      input  fifo_rdata,
      output fifo_ren,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_keep,
      output out_last
   );

   modport slave (
      output fifo_empty,
      output fifo_rdata,
      input  fifo_ren,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_keep,
      input  out_last
   );
endinterface
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_word_packer : packs fifo bytes into little-endian NBYTES-wide words
// rev 1.0
// ---------------------------------------------------------------------------
module fifo_word_packer #(
   parameter int NBYTES  = 4,
   parameter int TIMEOUT = 15
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          flush,
   output logic               busy,
   fifo_word_packer_if.master bus
);
   localparam int              CW     = $clog2(NBYTES + 1);
   localparam logic [CW-1:0]   C_FULL = CW'(NBYTES);

   logic [CW-1:0]          byte_cnt;
   logic [8*NBYTES-1:0]    acc;
   logic                   flush_pend;

   logic                   word_valid;
   logic [8*NBYTES-1:0]    word_data;
   logic [NBYTES-1:0]      word_keep;
   logic                   word_last;

   logic                   pop;
   logic                   full;
   logic                   partial;
   logic                   timeout_hit;
   logic                   emit_cause;
   logic                   slot_free;
   logic                   emit;
   logic [NBYTES-1:0]      keep_next;

   assign full       = (byte_cnt == C_FULL);
   assign partial    = (byte_cnt != '0) && !full;
   assign pop        = !rst && !bus.fifo_empty && !full && !flush_pend;
   assign emit_cause = full || (flush_pend && (byte_cnt != '0)) || timeout_hit;
   assign slot_free  = !word_valid || bus.out_ready;
   assign emit       = emit_cause && slot_free;

   // A timeout emit can coincide with a pop; that byte opens the next word.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt <= '0;
      end else if (emit) begin
         byte_cnt <= pop ? CW'(1) : '0;
      end else if (pop) begin
         byte_cnt <= byte_cnt + CW'(1);
      end
   end

   // Lanes above byte_cnt are kept at zero so the emitted word needs no mask.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (emit) begin
         acc <= '0;
         if (pop) begin
            acc[7:0] <= bus.fifo_rdata;
         end
      end else if (pop) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (byte_cnt == CW'(i)) begin
               acc[8*i +: 8] <= bus.fifo_rdata;
            end
         end
      end
   end

   // A flush seen on the emitting edge belongs to the next (possibly empty) word.
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_pend <= 1'b0;
      end else if (flush) begin
         flush_pend <= 1'b1;
      end else if (emit || (byte_cnt == '0)) begin
         flush_pend <= 1'b0;
      end
   end

   for (genvar g = 0; g < NBYTES; g++) begin : g_keep
      assign keep_next[g] = (byte_cnt > CW'(g));
   end

   generate
      if (TIMEOUT > 0) begin : g_timeout
         localparam int            IW     = $clog2(TIMEOUT + 1);
         localparam logic [IW-1:0] C_TMAX = IW'(TIMEOUT);
         logic [IW-1:0]            idle_cnt;

         always_ff @(posedge clk) begin
            if (rst || pop || emit) begin
               idle_cnt <= '0;
            end else if (partial && (idle_cnt != C_TMAX)) begin
               idle_cnt <= idle_cnt + IW'(1);
            end
         end

         assign timeout_hit = partial && (idle_cnt == C_TMAX);
      end else begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         word_valid <= 1'b0;
         word_data  <= '0;
         word_keep  <= '0;
         word_last  <= 1'b0;
      end else if (emit) begin
         word_valid <= 1'b1;
         word_data  <= acc;
         word_keep  <= keep_next;
         word_last  <= flush_pend;
      end else if (bus.out_ready) begin
         word_valid <= 1'b0;
      end
   end

   assign bus.fifo_ren  = pop;
   assign bus.out_valid = word_valid;
   assign bus.out_data  = word_data;
   assign bus.out_keep  = word_keep;
   assign bus.out_last  = word_last;
   assign busy          = (byte_cnt != '0) || word_valid || flush_pend;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_word_packer : randomized and directed bench with word scoreboard
// rev 1.0
// ---------------------------------------------------------------------------
module tb_fifo_word_packer;
   localparam int NB = 4;
   localparam int TO = 15;
   localparam int W  = 8 * NB;

   typedef struct {
      logic [W-1:0]  data;
      logic [NB-1:0] keep;
      logic          last;
   } exp_t;

   logic clk = 1'b0;
   logic rst, flush, busy;
   logic flush0, busy0;
   logic ren_q = 1'b0, ren0_q = 1'b0;

   fifo_word_packer_if #(.NBYTES(NB)) bus  ();
   fifo_word_packer_if #(.NBYTES(NB)) bus0 ();

   fifo_word_packer #(.NBYTES(NB), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .flush(flush), .busy(busy), .bus(bus)
   );
   fifo_word_packer #(.NBYTES(NB), .TIMEOUT(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush0), .busy(busy0), .bus(bus0)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] fq[$];
   logic [7:0] pend[$];
   exp_t       exp_q[$];
   logic [7:0] f0_byte = 8'h00;
   bit         f0_full = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive();
      bus.fifo_empty  = (fq.size() == 0);
      bus.fifo_rdata  = (fq.size() == 0) ? 8'h00 : fq[0];
      bus0.fifo_empty = !f0_full;
      bus0.fifo_rdata = f0_full ? f0_byte : 8'h00;
   endtask

   always @(posedge clk) begin
      ren_q  <= bus.fifo_ren;
      ren0_q <= bus0.fifo_ren;
   end

   task automatic step();
      @(posedge clk);
      #2;
      if (ren_q && fq.size() > 0) void'(fq.pop_front());
      if (ren0_q) f0_full = 1'b0;
      drive();
   endtask

   // Reference: the byte stream is cut into words every NB bytes, or at an explicit close.
   task automatic close_word(input bit last);
      exp_t e;
      int   n;
      n      = pend.size();
      e.data = '0;
      for (int i = 0; i < n; i++) e.data = e.data | (W'(pend[i]) << (8 * i));
      e.keep = NB'((1 << n) - 1);
      e.last = last;
      exp_q.push_back(e);
      pend.delete();
   endtask

   task automatic add_byte(input logic [7:0] b);
      fq.push_back(b);
      pend.push_back(b);
      if (pend.size() == NB) close_word(1'b0);
      drive();
   endtask

   task automatic drain(input string name);
      int n = 0;
      bus.out_ready = 1'b1;
      while ((exp_q.size() != 0 || fq.size() != 0) && n < 300) begin
         step();
         n++;
      end
      repeat (3) step();
      chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   // Monitor: scoreboard on each transfer, hold-stability under stall, fifo_ren legality.
   bit            prev_stall = 1'b0;
   logic [W-1:0]  prev_data;
   logic [NB-1:0] prev_keep;
   logic          prev_last;

   always @(negedge clk) begin
      exp_t e;
      chk("ren_legal", 64'(bus.fifo_ren && (bus.fifo_empty || rst)), 64'd0);
      chk("ren0_legal", 64'(bus0.fifo_ren && (bus0.fifo_empty || rst)), 64'd0);
      if (prev_stall) begin
         chk("hold_valid", 64'(bus.out_valid), 64'd1);
         chk("hold_data", 64'(bus.out_data), 64'(prev_data));
         chk("hold_keep_last", 64'({bus.out_keep, bus.out_last}), 64'({prev_keep, prev_last}));
      end
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got word %h with no word expected", bus.out_data);
         end else begin
            e = exp_q.pop_front();
            chk("sb_data", 64'(bus.out_data), 64'(e.data));
            chk("sb_keep", 64'(bus.out_keep), 64'(e.keep));
            chk("sb_last", 64'(bus.out_last), 64'(e.last));
         end
      end
      prev_stall = !rst && bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_keep  = bus.out_keep;
      prev_last  = bus.out_last;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, first, vcnt, rcnt;
      rst = 1'b1;
      flush = 1'b0;
      flush0 = 1'b0;
      bus.out_ready = 1'b1;
      bus0.out_ready = 1'b1;
      drive();
      repeat (3) step();
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_data", 64'(bus.out_data), 64'd0);
      chk("rst_keep_last", 64'({bus.out_keep, bus.out_last}), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      step();

      // full word, latency and single-cycle valid
      add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_byte(8'h44);
      first = 0; vcnt = 0; rcnt = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         rcnt += int'(ren_q);
         if (bus.out_valid) begin
            vcnt++;
            if (first == 0) first = i;
         end
      end
      chk("t1_ren_cycles", 64'(rcnt), 64'd4);
      chk("t1_latency", 64'(first), 64'd5);
      chk("t1_valid_cycles", 64'(vcnt), 64'd1);
      drain("t1");

      // flush closes a partial word; later bytes start the next word
      add_byte(8'hA1); add_byte(8'hA2); add_byte(8'hA3);
      repeat (5) step();
      pulse_flush();
      close_word(1'b1);
      add_byte(8'hB0); add_byte(8'hB1); add_byte(8'hB2); add_byte(8'hB3);
      drain("t2");

      // idle timeout: 1 pop edge + TO idle edges + 1 emit edge
      add_byte(8'h5C);
      close_word(1'b0);
      first = 0;
      for (int i = 1; i <= 40 && first == 0; i++) begin
         step();
         if (bus.out_valid) first = i;
      end
      chk("t3_timeout_latency", 64'(first), 64'(TO + 2));
      drain("t3");

      // timeout disabled: no emit, only a flush closes the word
      f0_byte = 8'h5C;
      f0_full = 1'b1;
      drive();
      vcnt = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         vcnt += int'(bus0.out_valid);
      end
      chk("t3_no_timeout", 64'(vcnt), 64'd0);
      flush0 = 1'b1;
      step();
      flush0 = 1'b0;
      first = 0;
      for (int i = 0; i < 5 && first == 0; i++) begin
         step();
         if (bus0.out_valid) begin
            first = 1;
            chk("t3_t0_data", 64'(bus0.out_data), 64'h0000005C);
            chk("t3_t0_keep_last", 64'({bus0.out_keep, bus0.out_last}), 64'({4'b0001, 1'b1}));
         end
      end
      chk("t3_t0_emitted", 64'(first), 64'd1);

      // backpressure: second word packs, fifo absorbs the rest
      bus.out_ready = 1'b0;
      for (int i = 0; i < 12; i++) add_byte(8'(8'hC0 + i));
      repeat (20) step();
      chk("t4_valid_held", 64'(bus.out_valid), 64'd1);
      chk("t4_fifo_left", 64'(fq.size()), 64'd4);
      chk("t4_ren_stopped", 64'(bus.fifo_ren), 64'd0);
      bus.out_ready = 1'b1;
      step();
      chk("t4_back_to_back", 64'(bus.out_valid), 64'd1);
      drain("t4");

      // reset mid-word with a pending output word
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) add_byte(8'(8'hD0 + i));
      repeat (10) step();
      chk("t5_pre_valid", 64'(bus.out_valid), 64'd1);
      rst = 1'b1;
      exp_q.delete();
      pend.delete();
      fq.delete();
      drive();
      step();
      rst = 1'b0;
      chk("t5_valid", 64'(bus.out_valid), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
      bus.out_ready = 1'b1;
      add_byte(8'hE1); add_byte(8'hE2); add_byte(8'hE3); add_byte(8'hE4);
      drain("t5");

      // flush with nothing packed
      pulse_flush();
      chk("t6_busy_pend", 64'(busy), 64'd1);
      step();
      chk("t6_busy_clear", 64'(busy), 64'd0);
      vcnt = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         vcnt += int'(bus.out_valid);
      end
      chk("t6_no_word", 64'(vcnt), 64'd0);

      // random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) != 0 && fq.size() < 8) add_byte(8'($urandom));
         step();
      end
      k = 0;
      bus.out_ready = 1'b1;
      while (fq.size() != 0 && k < 200) begin
         step();
         k++;
      end
      repeat (3) step();
      if (pend.size() != 0) begin
         pulse_flush();
         close_word(1'b1);
      end
      drain("rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
